// File: rtl/dm_port_arbiter_if.sv
// Two-requester data-RAM port bundle: requester side, arbiter side and the RAM pins.
// The arbiter uses modport slave; the requesters and RAM model use master.
interface dm_port_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [3:0]  m0_wen;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [3:0]  m1_wen;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic [31:0] ram_addr;
    logic [3:0]  ram_wen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  m0_req, m0_addr, m0_wen, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_wen, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_addr, ram_wen, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output m0_req, m0_addr, m0_wen, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_wen, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_addr, ram_wen, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares one synchronous-read data RAM port between the MEM stage (port 0) and a secondary port (port 1).
// Fixed priority with a starvation counter by default; define DM_ARB_RR_EN for 2-way round-robin.
module dm_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic             clk,
    input logic             resetn,
    dm_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       pick1;
    logic       gnt0, gnt1;
    logic [1:0] rd_pend;
    logic [3:0] starve_cnt;

`ifdef DM_ARB_RR_EN
    logic rr_pref1;  // 1: port 0 was granted last, so port 1 wins the next tie

    assign starve_cnt = 4'd0;
    assign pick1 = bus.m1_req && (!bus.m0_req || rr_pref1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)            rr_pref1 <= 1'b0;
        else if (gnt0 || gnt1)  rr_pref1 <= gnt0;
    end
`else
    assign pick1 = bus.m1_req && (!bus.m0_req || starve_cnt == STARVE_LIM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                     starve_cnt <= 4'd0;
        else if (!bus.m1_req || gnt1)    starve_cnt <= 4'd0;
        else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
    end
`endif

    // Grants are suppressed combinationally while reset is held
    assign gnt1 = resetn && pick1;
    assign gnt0 = resetn && bus.m0_req && !pick1;

    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;

    always_comb begin
        bus.ram_addr  = bus.m0_addr;
        bus.ram_wdata = bus.m0_wdata;
        bus.ram_wen   = 4'd0;
        if (gnt1) begin
            bus.ram_addr  = bus.m1_addr;
            bus.ram_wdata = bus.m1_wdata;
            bus.ram_wen   = bus.m1_wen;
        end else if (gnt0) begin
            bus.ram_wen   = bus.m0_wen;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rd_pend <= 2'b00;
        else         rd_pend <= {gnt1 && (bus.m1_wen == 4'd0), gnt0 && (bus.m0_wen == 4'd0)};
    end

    assign bus.m0_rvalid = rd_pend[0];
    assign bus.m1_rvalid = rd_pend[1];
    assign bus.m0_rdata  = bus.ram_rdata;
    assign bus.m1_rdata  = bus.ram_rdata;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small byte-writable synchronous-read RAM model.
module tb_dm_port_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    dm_port_arbiter_if bus ();

    dm_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // RAM model: word-addressed, one-cycle read latency, byte write enables
    logic [31:0] mem [0:63];
    logic [31:0] rdata_q;
    always @(posedge clk) begin
        rdata_q <= mem[bus.ram_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (bus.ram_wen[b]) mem[bus.ram_addr[7:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    assign bus.ram_rdata = rdata_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic req, input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd);
        bus.m0_req = req; bus.m0_addr = addr; bus.m0_wen = wen; bus.m0_wdata = wd;
    endtask

    task automatic set1(input logic req, input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd);
        bus.m1_req = req; bus.m1_addr = addr; bus.m1_wen = wen; bus.m1_wdata = wd;
    endtask

    int r1 [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int e1 [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h1234_5678;   // addr 0x10
        mem[8] = 32'h1122_3344;   // addr 0x20
        set0(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        set1(1'b1, 32'h20, 4'h0, 32'h0);

        // Reset: grants and write enables forced low, no rvalid
        #2;
        chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(bus.m1_gnt), 32'd0);
        chk("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
        tick();
        chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
        set0(1'b0, 32'h0, 4'h0, 32'h0);
        set1(1'b0, 32'h0, 4'h0, 32'h0);
        resetn = 1'b1;
        tick();

        // Single read by port 0
        set0(1'b1, 32'h10, 4'h0, 32'h0);
        #1;
        chk("rd_m0_gnt", 32'(bus.m0_gnt), 32'd1);
        chk("rd_m1_gnt", 32'(bus.m1_gnt), 32'd0);
        chk("rd_ram_addr", bus.ram_addr, 32'h10);
        chk("rd_ram_wen", 32'(bus.ram_wen), 32'd0);
        tick();
        set0(1'b0, 32'h0, 4'h0, 32'h0);
        chk("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
        chk("rd_m0_rdata", bus.m0_rdata, 32'h1234_5678);
        chk("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
        tick();
        chk("rd_m0_rvalid_once", 32'(bus.m0_rvalid), 32'd0);

        // Single byte write by port 1, then read back
        set1(1'b1, 32'h20, 4'b0010, 32'h0000_AB00);
        #1;
        chk("wr_m1_gnt", 32'(bus.m1_gnt), 32'd1);
        chk("wr_ram_wen", 32'(bus.ram_wen), 32'b0010);
        chk("wr_ram_addr", bus.ram_addr, 32'h20);
        chk("wr_ram_wdata", bus.ram_wdata, 32'h0000_AB00);
        tick();
        set1(1'b0, 32'h0, 4'h0, 32'h0);
        chk("wr_no_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
        chk("wr_no_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
        set1(1'b1, 32'h20, 4'h0, 32'h0);
        #1;
        chk("rb_m1_gnt", 32'(bus.m1_gnt), 32'd1);
        tick();
        set1(1'b0, 32'h0, 4'h0, 32'h0);
        chk("rb_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
        chk("rb_m1_rdata", bus.m1_rdata, 32'h1122_AB44);
        chk("rb_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);

        // Idle: nothing granted, RAM address follows port 0 address
        set0(1'b0, 32'h44, 4'hF, 32'h5555_AAAA);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
            chk("idle_ram_wen", 32'(bus.ram_wen), 32'd0);
            chk("idle_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        end
        chk("idle_ram_addr", bus.ram_addr, 32'h44);
        chk("idle_ram_wdata", bus.ram_wdata, 32'h5555_AAAA);
        set0(1'b0, 32'h0, 4'h0, 32'h0);

        // Reset asserted with a read pending: the read is dropped
        set0(1'b1, 32'h10, 4'h0, 32'h0);
        #1;
        chk("rstrd_m0_gnt", 32'(bus.m0_gnt), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rstrd_gnt_forced", 32'(bus.m0_gnt), 32'd0);
        set0(1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        resetn = 1'b1;
        chk("rstrd_no_rvalid0", 32'(bus.m0_rvalid), 32'd0);
        tick();
        chk("rstrd_no_rvalid1", 32'(bus.m0_rvalid), 32'd0);

        // First tie after reset goes to port 0, then continuous contention
        set0(1'b1, 32'h10, 4'h0, 32'h0);
        set1(1'b1, 32'h20, 4'h0, 32'h0);
`ifndef DM_ARB_RR_EN
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("stv_m0_gnt", 32'(bus.m0_gnt), (i == 4) ? 32'd0 : 32'd1);
            chk("stv_m1_gnt", 32'(bus.m1_gnt), (i == 4) ? 32'd1 : 32'd0);
            tick();
            chk("stv_m0_rvalid", 32'(bus.m0_rvalid), (i == 4) ? 32'd0 : 32'd1);
            chk("stv_m1_rvalid", 32'(bus.m1_rvalid), (i == 4) ? 32'd1 : 32'd0);
            chk("stv_rdata", bus.m0_rdata, (i == 4) ? 32'h1122_AB44 : 32'h1234_5678);
        end
        set1(1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        // Dropping port 1 request clears the starvation count
        for (int i = 0; i < 9; i++) begin
            bus.m1_req = r1[i][0];
            #1;
            chk("clr_m1_gnt", 32'(bus.m1_gnt), 32'(e1[i]));
            chk("clr_m0_gnt", 32'(bus.m0_gnt), 32'(1 - e1[i]));
            tick();
        end
`else
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_m0_gnt", 32'(bus.m0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_m1_gnt", 32'(bus.m1_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_m0_rvalid", 32'(bus.m0_rvalid), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_m1_rvalid", 32'(bus.m1_rvalid), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_rdata", bus.m0_rdata, (i % 2 == 1) ? 32'h1122_AB44 : 32'h1234_5678);
        end
`endif
        set0(1'b0, 32'h0, 4'h0, 32'h0);
        set1(1'b0, 32'h0, 4'h0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
